// File: rtl/frv_axi_demux_if.sv
// AXI4-lite bus bundle (32b data, 1b id) with master/slave views.
interface frv_axi_demux_if;
  logic        awvalid;
  logic        awready;
  logic        awid;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        bid;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic        arid;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic        rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arprot, input arready,
    input  rvalid, rid, rdata, rresp, output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arprot, output arready,
    output rvalid, rid, rdata, rresp, input rready
  );
endinterface

// File: rtl/frv_axi_demux.sv
// Single-master to dual-slave AXI4-lite address demux with ordered responses.
// Combinational forwarding; per-direction target and outstanding counters.
module frv_axi_demux #(
  parameter logic [31:0] M1_BASE = 32'h4000_0000,
  parameter logic [31:0] M1_MASK = 32'hF000_0000,
  parameter int unsigned OUTS_W  = 2
) (
  input  logic             aclk,
  input  logic             areset,
  frv_axi_demux_if.slave   s0,
  frv_axi_demux_if.master  m0,
  frv_axi_demux_if.master  m1
);
  localparam logic [OUTS_W-1:0] OUTS_MAX = '1;
  localparam logic [OUTS_W-1:0] OUTS_ONE = OUTS_W'(1);

  logic              w_sel, r_sel;
  logic [OUTS_W-1:0] w_out, w_pend, r_out;

  logic aw_tgt, aw_ok, aw_hs, w_en, w_hs, b_en, b_hs;
  logic ar_tgt, ar_ok, ar_hs, r_en, r_hs;

  // Payload is broadcast; only valid/ready are steered.
  assign m0.awid   = s0.awid;    assign m1.awid   = s0.awid;
  assign m0.awaddr = s0.awaddr;  assign m1.awaddr = s0.awaddr;
  assign m0.awprot = s0.awprot;  assign m1.awprot = s0.awprot;
  assign m0.wdata  = s0.wdata;   assign m1.wdata  = s0.wdata;
  assign m0.wstrb  = s0.wstrb;   assign m1.wstrb  = s0.wstrb;
  assign m0.arid   = s0.arid;    assign m1.arid   = s0.arid;
  assign m0.araddr = s0.araddr;  assign m1.araddr = s0.araddr;
  assign m0.arprot = s0.arprot;  assign m1.arprot = s0.arprot;

  assign s0.bid   = w_sel ? m1.bid   : m0.bid;
  assign s0.bresp = w_sel ? m1.bresp : m0.bresp;
  assign s0.rid   = r_sel ? m1.rid   : m0.rid;
  assign s0.rdata = r_sel ? m1.rdata : m0.rdata;
  assign s0.rresp = r_sel ? m1.rresp : m0.rresp;

  // A new target is only accepted once the other one has fully drained.
  assign aw_tgt = (s0.awaddr & M1_MASK) == M1_BASE;
  assign aw_ok  = !areset && (w_out != OUTS_MAX) && ((w_out == '0) || (aw_tgt == w_sel));
  assign ar_tgt = (s0.araddr & M1_MASK) == M1_BASE;
  assign ar_ok  = !areset && (r_out != OUTS_MAX) && ((r_out == '0) || (ar_tgt == r_sel));
  assign w_en   = !areset && (w_pend != '0);
  assign b_en   = !areset && (w_out != '0);
  assign r_en   = !areset && (r_out != '0);

  always_comb begin
    m0.awvalid = aw_ok && !aw_tgt && s0.awvalid;
    m1.awvalid = aw_ok &&  aw_tgt && s0.awvalid;
    s0.awready = aw_ok && (aw_tgt ? m1.awready : m0.awready);

    m0.wvalid  = w_en && !w_sel && s0.wvalid;
    m1.wvalid  = w_en &&  w_sel && s0.wvalid;
    s0.wready  = w_en && (w_sel ? m1.wready : m0.wready);

    s0.bvalid  = b_en && (w_sel ? m1.bvalid : m0.bvalid);
    m0.bready  = b_en && !w_sel && s0.bready;
    m1.bready  = b_en &&  w_sel && s0.bready;

    m0.arvalid = ar_ok && !ar_tgt && s0.arvalid;
    m1.arvalid = ar_ok &&  ar_tgt && s0.arvalid;
    s0.arready = ar_ok && (ar_tgt ? m1.arready : m0.arready);

    s0.rvalid  = r_en && (r_sel ? m1.rvalid : m0.rvalid);
    m0.rready  = r_en && !r_sel && s0.rready;
    m1.rready  = r_en &&  r_sel && s0.rready;
  end

  assign aw_hs = s0.awvalid && s0.awready;
  assign w_hs  = s0.wvalid  && s0.wready;
  assign b_hs  = s0.bvalid  && s0.bready;
  assign ar_hs = s0.arvalid && s0.arready;
  assign r_hs  = s0.rvalid  && s0.rready;

  // Target and outstanding bookkeeping; simultaneous inc/dec cancel out.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_sel  <= 1'b0;
      r_sel  <= 1'b0;
      w_out  <= '0;
      w_pend <= '0;
      r_out  <= '0;
    end else begin
      if (aw_hs) w_sel <= aw_tgt;
      if (ar_hs) r_sel <= ar_tgt;

      if (aw_hs && !b_hs)      w_out <= w_out + OUTS_ONE;
      else if (!aw_hs && b_hs) w_out <= w_out - OUTS_ONE;

      if (aw_hs && !w_hs)      w_pend <= w_pend + OUTS_ONE;
      else if (!aw_hs && w_hs) w_pend <= w_pend - OUTS_ONE;

      if (ar_hs && !r_hs)      r_out <= r_out + OUTS_ONE;
      else if (!ar_hs && r_hs) r_out <= r_out - OUTS_ONE;
    end
  end
endmodule

// File: tb/tb_frv_axi_demux.sv
// Directed bench for frv_axi_demux: queue-based response-order model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_frv_axi_demux;
  localparam int unsigned MAXO = 3;

  logic aclk = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  frv_axi_demux_if s0 ();
  frv_axi_demux_if m0 ();
  frv_axi_demux_if m1 ();

  frv_axi_demux #(.M1_BASE(32'h4000_0000), .M1_MASK(32'hF000_0000), .OUTS_W(2)) dut (
    .aclk(aclk), .areset(areset), .s0(s0), .m0(m0), .m1(m1)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit dec(input logic [31:0] a);
    return (a & 32'hF000_0000) == 32'h4000_0000;
  endfunction

  // Model: one queue entry per accepted address awaiting its response.
  bit wq[$];
  bit rq[$];
  int w_pend_m = 0;
  bit w_last = 1'b0;

  logic [14:0] exp_ctl, act_ctl;

  always @(negedge aclk) begin
    bit ta, tr, aw_ok, ar_ok, bt, rt, wn, bn, rn;
    bit e_awr, e_wr, e_bv, e_arr, e_rv;
    bit e_aw0, e_aw1, e_w0, e_w1, e_b0, e_b1, e_ar0, e_ar1, e_r0, e_r1;
    act_ctl = {s0.awready, s0.wready, s0.bvalid, s0.arready, s0.rvalid,
               m0.awvalid, m0.wvalid, m0.bready, m0.arvalid, m0.rready,
               m1.awvalid, m1.wvalid, m1.bready, m1.arvalid, m1.rready};
    if (areset) begin
      chk("ctl_reset", 128'(act_ctl), 128'(0));
      wq.delete(); rq.delete(); w_pend_m = 0; w_last = 1'b0;
    end else begin
      ta = dec(s0.awaddr);
      tr = dec(s0.araddr);
      bn = wq.size() != 0;
      rn = rq.size() != 0;
      wn = w_pend_m != 0;
      bt = bn ? wq[0] : 1'b0;
      rt = rn ? rq[0] : 1'b0;
      aw_ok = (wq.size() < MAXO) && (!bn || wq[wq.size()-1] == ta);
      ar_ok = (rq.size() < MAXO) && (!rn || rq[rq.size()-1] == tr);

      e_awr = aw_ok && (ta ? m1.awready : m0.awready);
      e_aw0 = aw_ok && !ta && s0.awvalid;
      e_aw1 = aw_ok &&  ta && s0.awvalid;
      e_wr  = wn && (w_last ? m1.wready : m0.wready);
      e_w0  = wn && !w_last && s0.wvalid;
      e_w1  = wn &&  w_last && s0.wvalid;
      e_bv  = bn && (bt ? m1.bvalid : m0.bvalid);
      e_b0  = bn && !bt && s0.bready;
      e_b1  = bn &&  bt && s0.bready;
      e_arr = ar_ok && (tr ? m1.arready : m0.arready);
      e_ar0 = ar_ok && !tr && s0.arvalid;
      e_ar1 = ar_ok &&  tr && s0.arvalid;
      e_rv  = rn && (rt ? m1.rvalid : m0.rvalid);
      e_r0  = rn && !rt && s0.rready;
      e_r1  = rn &&  rt && s0.rready;

      exp_ctl = {e_awr, e_wr, e_bv, e_arr, e_rv,
                 e_aw0, e_w0, e_b0, e_ar0, e_r0,
                 e_aw1, e_w1, e_b1, e_ar1, e_r1};
      chk("ctl", 128'(act_ctl), 128'(exp_ctl));
      chk("aw_payload", 128'({m0.awid, m0.awaddr, m0.awprot, m1.awid, m1.awaddr, m1.awprot}),
          128'({s0.awid, s0.awaddr, s0.awprot, s0.awid, s0.awaddr, s0.awprot}));
      chk("ar_payload", 128'({m0.arid, m0.araddr, m0.arprot, m1.arid, m1.araddr, m1.arprot}),
          128'({s0.arid, s0.araddr, s0.arprot, s0.arid, s0.araddr, s0.arprot}));
      if (e_w0 || e_w1)
        chk("w_payload", 128'(e_w1 ? {m1.wdata, m1.wstrb} : {m0.wdata, m0.wstrb}),
            128'({s0.wdata, s0.wstrb}));
      if (e_bv)
        chk("b_payload", 128'({s0.bid, s0.bresp}),
            128'(bt ? {m1.bid, m1.bresp} : {m0.bid, m0.bresp}));
      if (e_rv)
        chk("r_payload", 128'({s0.rid, s0.rdata, s0.rresp}),
            128'(rt ? {m1.rid, m1.rdata, m1.rresp} : {m0.rid, m0.rdata, m0.rresp}));

      // Apply this cycle's handshakes for the coming edge.
      if (e_bv && s0.bready) void'(wq.pop_front());
      if (s0.awvalid && e_awr) begin wq.push_back(ta); w_last = ta; w_pend_m++; end
      if (s0.wvalid && e_wr) w_pend_m--;
      if (e_rv && s0.rready) void'(rq.pop_front());
      if (s0.arvalid && e_arr) rq.push_back(tr);
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    areset = 1'b1;
    s0.awvalid = 0; s0.awid = 0; s0.awaddr = 0; s0.awprot = 0;
    s0.wvalid = 0; s0.wdata = 0; s0.wstrb = 0; s0.bready = 0;
    s0.arvalid = 0; s0.arid = 0; s0.araddr = 0; s0.arprot = 0; s0.rready = 0;
    m0.awready = 0; m0.wready = 0; m0.bvalid = 0; m0.bid = 0; m0.bresp = 0;
    m0.arready = 0; m0.rvalid = 0; m0.rid = 0; m0.rdata = 0; m0.rresp = 0;
    m1.awready = 0; m1.wready = 0; m1.bvalid = 0; m1.bid = 0; m1.bresp = 0;
    m1.arready = 0; m1.rvalid = 0; m1.rid = 0; m1.rdata = 0; m1.rresp = 0;

    // 1: reset with pending upstream valid
    s0.awvalid = 1; s0.awaddr = 32'h0000_0040; m0.awready = 1;
    settle();
    chk("t1_m0_awvalid", 128'(m0.awvalid), 128'(0));
    chk("t1_s0_awready", 128'(s0.awready), 128'(0));
    step(); step();
    chk("t1_m1_awvalid", 128'(m1.awvalid), 128'(0));
    areset = 0; s0.awvalid = 0; m0.awready = 0;
    step();
    chk("t1_model_empty", 128'(wq.size() + rq.size()), 128'(0));

    // 2: single write to m1
    s0.awvalid = 1; s0.awaddr = 32'h4000_0010; s0.awid = 1; s0.awprot = 3'd2;
    s0.wvalid = 1; s0.wdata = 32'hDEAD_BEEF; s0.wstrb = 4'hF;
    m1.awready = 1; m1.wready = 1;
    settle();
    chk("t2_m1_awvalid", 128'(m1.awvalid), 128'(1));
    chk("t2_m0_awvalid", 128'(m0.awvalid), 128'(0));
    chk("t2_m1_awaddr", 128'(m1.awaddr), 128'(32'h4000_0010));
    chk("t2_wready_before_aw", 128'(s0.wready), 128'(0));
    step();
    s0.awvalid = 0;
    settle();
    chk("t2_m1_w", 128'({m1.wvalid, m1.wdata, m0.wvalid}), 128'({1'b1, 32'hDEAD_BEEF, 1'b0}));
    step();
    s0.wvalid = 0;
    m1.bvalid = 1; m1.bid = 1; m1.bresp = 2'b00; s0.bready = 1;
    settle();
    chk("t2_b", 128'({s0.bvalid, s0.bid, s0.bresp, m1.bready}), 128'({1'b1, 1'b1, 2'b00, 1'b1}));
    step();
    chk("t2_b_ignored", 128'({s0.bvalid, m1.bready}), 128'(0));
    chk("t2_model_wout", 128'(wq.size()), 128'(0));
    m1.bvalid = 0; s0.bready = 0; m1.awready = 0; m1.wready = 0;
    step();

    // 3: read m0 then m1, m0 response delayed
    s0.arvalid = 1; s0.araddr = 32'h0000_0100; s0.arid = 0;
    m0.arready = 1; m1.arready = 1; s0.rready = 1;
    settle();
    chk("t3_m0_arvalid", 128'(m0.arvalid), 128'(1));
    step();
    s0.araddr = 32'h4000_0000; s0.arid = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3_m1_ar_held", 128'({m1.arvalid, s0.arready}), 128'(0));
      step();
    end
    m0.rvalid = 1; m0.rid = 0; m0.rdata = 32'h1111_0000; m0.rresp = 0;
    settle();
    chk("t3_r0", 128'({s0.rvalid, s0.rid, s0.rdata}), 128'({1'b1, 1'b0, 32'h1111_0000}));
    chk("t3_m1_ar_still_held", 128'(m1.arvalid), 128'(0));
    step();
    m0.rvalid = 0;
    settle();
    chk("t3_m1_arvalid", 128'(m1.arvalid), 128'(1));
    step();
    s0.arvalid = 0;
    m1.rvalid = 1; m1.rid = 1; m1.rdata = 32'h2222_0001; m1.rresp = 0;
    m0.rvalid = 1; m0.rdata = 32'hBAD0_BAD0;
    settle();
    chk("t3_r1", 128'({s0.rvalid, s0.rid, s0.rdata, m0.rready}), 128'({1'b1, 1'b1, 32'h2222_0001, 1'b0}));
    step();
    m1.rvalid = 0; m0.rvalid = 0; s0.rready = 0; m0.arready = 0; m1.arready = 0;
    chk("t3_model_rout", 128'(rq.size()), 128'(0));
    step();

    // 4: outstanding limit on m0
    s0.awvalid = 1; s0.awaddr = 32'h0000_0200; s0.awid = 0;
    s0.wvalid = 1; s0.wdata = 32'h0000_00A5; s0.wstrb = 4'h1;
    m0.awready = 1; m0.wready = 1;
    step(); step(); step();
    chk("t4_model_full", 128'(wq.size()), 128'(3));
    chk("t4_stall", 128'({s0.awready, m0.awvalid}), 128'(0));
    step();
    chk("t4_stall2", 128'(s0.awready), 128'(0));
    m0.bvalid = 1; m0.bresp = 0; s0.bready = 1;
    settle();
    chk("t4_stall_during_b", 128'(s0.awready), 128'(0));
    step();
    m0.bvalid = 0;
    settle();
    chk("t4_accept_after_b", 128'({s0.awready, m0.awvalid}), 128'({1'b1, 1'b1}));
    step();
    s0.awvalid = 0;
    m0.bvalid = 1;
    step(); step(); step();
    m0.bvalid = 0; s0.wvalid = 0; s0.bready = 0; m0.awready = 0; m0.wready = 0;
    chk("t4_model_drained", 128'(wq.size()), 128'(0));
    step();

    // 5: W ahead of AW
    s0.wvalid = 1; s0.wdata = 32'h5555_AAAA; s0.wstrb = 4'hC;
    m0.wready = 1; m1.wready = 1;
    settle();
    chk("t5_w_blocked", 128'({s0.wready, m0.wvalid, m1.wvalid}), 128'(0));
    step();
    chk("t5_w_blocked2", 128'(s0.wready), 128'(0));
    s0.awvalid = 1; s0.awaddr = 32'h4000_0100; m1.awready = 1;
    settle();
    chk("t5_w_blocked_aw_cycle", 128'(s0.wready), 128'(0));
    step();
    s0.awvalid = 0;
    settle();
    chk("t5_w_routed", 128'({m1.wvalid, s0.wready, m0.wvalid}), 128'({1'b1, 1'b1, 1'b0}));
    step();
    s0.wvalid = 0;
    m1.bvalid = 1; s0.bready = 1;
    step();
    m1.bvalid = 0; s0.bready = 0; m1.awready = 0; m0.wready = 0; m1.wready = 0;
    step();

    // 6: B and AW handshake in the same cycle
    s0.awvalid = 1; s0.awaddr = 32'h0000_0300;
    s0.wvalid = 1; s0.wdata = 32'h6666_0000; s0.wstrb = 4'hF;
    m0.awready = 1; m0.wready = 1;
    step();
    s0.awvalid = 0;
    step();
    s0.wvalid = 0;
    m0.bvalid = 1; s0.bready = 1;
    s0.awvalid = 1; s0.awaddr = 32'h0000_0304;
    settle();
    chk("t6_both_ready", 128'({s0.awready, s0.bvalid}), 128'({1'b1, 1'b1}));
    step();
    s0.awvalid = 0; s0.wvalid = 1;
    chk("t6_model_wout", 128'(wq.size()), 128'(1));
    settle();
    chk("t6_b_still_valid", 128'(s0.bvalid), 128'(1));
    step();
    s0.wvalid = 0;
    settle();
    chk("t6_drained", 128'({s0.bvalid, m0.bready}), 128'(0));
    m0.bvalid = 0; s0.bready = 0; m0.awready = 0; m0.wready = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
